btn_event_gen: RTL and testbench



---
 rtl/btn_pkg.sv | 17 +
 rtl/btn_channel.sv | 95 +++++++++
 rtl/btn_event_gen.sv | 37 +++
 tb/tb_btn_event_gen.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// btn_pkg: shared button FSM states, default timing, channel indices and helper
package btn_pkg;
  typedef enum logic [2:0] {ARM, IDLE, DEB_PRESS, PRESSED, HELD, DEB_RELEASE} btn_state_e;
  localparam int DEF_NUM_BTN = 5;
  localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
  localparam int DEF_HOLD_CYCLES = 15_000_000;
  localparam int DEF_REPEAT_CYCLES = 10_000_000;
  localparam logic [4:0] DEF_REPEAT_MASK = 5'b01000;
  localparam int BTN_START_STOP = 0;
  localparam int BTN_MODE = 1;
  localparam int BTN_EDIT_SHIFT = 2;
  localparam int BTN_INC = 3;
  localparam int BTN_RESET = 4;
  function automatic int max_i(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/btn_channel.sv
// btn_channel: one button sync/debounce/hold/repeat; in clk, reset (async low), raw; out level, press, release_ev, hold, repeat_ev
module btn_channel
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES,
  parameter bit REPEAT_EN = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic press,
  output logic release_ev,
  output logic hold,
  output logic repeat_ev
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int HW = $clog2(max_i(HOLD_CYCLES, REPEAT_CYCLES));
  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DW-1:0] DEB_TERM = DW'(DEBOUNCE_CYCLES - 2);
  localparam logic [HW-1:0] HOLD_TERM = HW'(HOLD_CYCLES - 1);
  localparam logic [HW-1:0] REP_TERM = HW'(REPEAT_CYCLES - 1);
  logic [1:0] sync;
  logic s;
  btn_state_e state;
  logic [DW-1:0] deb_cnt;
  logic [HW-1:0] hold_cnt;
  logic held;
  logic hold_term;
  assign s = sync[1];
  assign hold_term = hold_cnt == (held ? REP_TERM : HOLD_TERM);
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      sync <= '0;
      state <= ARM;
      deb_cnt <= '0;
      hold_cnt <= '0;
      held <= 1'b0;
      level <= 1'b0;
      press <= 1'b0;
      release_ev <= 1'b0;
      hold <= 1'b0;
      repeat_ev <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      press <= 1'b0;
      release_ev <= 1'b0;
      hold <= 1'b0;
      repeat_ev <= 1'b0;
      if (state inside {PRESSED, HELD, DEB_RELEASE}) hold_cnt <= hold_term ? '0 : hold_cnt + 1'b1;
      case (state)
        ARM: begin
          deb_cnt <= (s || deb_cnt == DEB_LAST) ? '0 : deb_cnt + 1'b1;
          if (!s && deb_cnt == DEB_LAST) state <= IDLE;
        end
        IDLE:
          if (s) begin
            state <= DEB_PRESS;
            deb_cnt <= '0;
          end
        DEB_PRESS:
          if (!s) state <= IDLE;
          else if (deb_cnt == DEB_TERM) begin
            state <= PRESSED;
            press <= 1'b1;
            level <= 1'b1;
            hold_cnt <= '0;
            held <= 1'b0;
          end else deb_cnt <= deb_cnt + 1'b1;
        PRESSED, HELD: begin
          if (hold_term) begin
            held <= 1'b1;
            hold <= !held;
            repeat_ev <= held && REPEAT_EN;
          end
          if (!s) begin
            state <= DEB_RELEASE;
            deb_cnt <= '0;
          end else if (hold_term) state <= HELD;
        end
        DEB_RELEASE: begin
          if (hold_term) held <= 1'b1;
          if (s) state <= (held || hold_term) ? HELD : PRESSED;
          else if (deb_cnt == DEB_TERM) begin
            state <= IDLE;
            release_ev <= 1'b1;
            level <= 1'b0;
          end else deb_cnt <= deb_cnt + 1'b1;
        end
        default: state <= ARM;
      endcase
    end
endmodule

// File: rtl/btn_event_gen.sv
// btn_event_gen: NUM_BTN button channels; in clk, reset (async low), btn_raw; out btn_level, btn_press, btn_release, btn_hold, btn_repeat
module btn_event_gen
  import btn_pkg::*;
#(
  parameter int NUM_BTN = DEF_NUM_BTN,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES,
  parameter logic [NUM_BTN-1:0] REPEAT_MASK = DEF_REPEAT_MASK
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  output logic [NUM_BTN-1:0] btn_hold,
  output logic [NUM_BTN-1:0] btn_repeat
);
  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    btn_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .HOLD_CYCLES(HOLD_CYCLES),
      .REPEAT_CYCLES(REPEAT_CYCLES),
      .REPEAT_EN(REPEAT_MASK[i])
    ) u_ch (
      .clk(clk),
      .reset(reset),
      .raw(btn_raw[i]),
      .level(btn_level[i]),
      .press(btn_press[i]),
      .release_ev(btn_release[i]),
      .hold(btn_hold[i]),
      .repeat_ev(btn_repeat[i])
    );
  end
endmodule

// File: tb/tb_btn_event_gen.sv
// tb_btn_event_gen: directed scoreboard bench for btn_event_gen
module tb_btn_event_gen;
  import btn_pkg::*;
  localparam int EV_PRESS = 0;
  localparam int EV_REL = 1;
  localparam int EV_HOLD = 2;
  localparam int EV_REP = 3;
  typedef struct {
    int cyc;
    int ch;
    int kind;
  } ev_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [4:0] btn_raw = '0;
  logic [4:0] btn_level, btn_press, btn_release, btn_hold, btn_repeat;
  logic [3:0][4:0] ev;
  ev_t q[$];
  string kn[4] = '{"press", "release", "hold", "repeat"};
  int cyc = 0;
  int total = 0;
  int bad = 0;
  int idx, want, t;
  btn_event_gen #(
    .NUM_BTN(5),
    .DEBOUNCE_CYCLES(4),
    .HOLD_CYCLES(20),
    .REPEAT_CYCLES(8),
    .REPEAT_MASK(5'b01000)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn_raw(btn_raw),
    .btn_level(btn_level),
    .btn_press(btn_press),
    .btn_release(btn_release),
    .btn_hold(btn_hold),
    .btn_repeat(btn_repeat)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign ev = {btn_repeat, btn_hold, btn_release, btn_press};
  always @(negedge clk)
    for (int k = 0; k < 4; k++)
      for (int c = 0; c < 5; c++)
        if (ev[k][c]) begin
          idx = -1;
          foreach (q[j]) if (idx < 0 && q[j].ch == c && q[j].kind == k) idx = j;
          want = idx < 0 ? -1 : q[idx].cyc;
          total++;
          assert (want == cyc) else begin
            bad++;
            $error("FAIL %s ch%0d pulse at cyc=%0d expected cyc=%0d (-1 means none pending)", kn[k], c, cyc, want);
          end
          if (idx >= 0) q.delete(idx);
        end
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic push(input int c, input int ch, input int k);
    q.push_back('{c, ch, k});
  endtask
  task automatic chk(input string tag, input logic [4:0] got, input logic [4:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%b want=%b", tag, got, exp);
    end
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_level"}, btn_level, 5'b0);
    chk({tag, "_press"}, btn_press, 5'b0);
    chk({tag, "_release"}, btn_release, 5'b0);
    chk({tag, "_hold"}, btn_hold, 5'b0);
    chk({tag, "_repeat"}, btn_repeat, 5'b0);
  endtask
  task automatic drained(input string tag);
    total++;
    assert (q.size() == 0) else begin
      bad++;
      $error("FAIL %s pending=%0d want=0", tag, q.size());
    end
  endtask
  initial begin
    #3 reset = 1'b0;
    step(2);
    chk_zero("reset");
    reset = 1'b1;
    step(12);
    step(1);
    t = cyc;
    btn_raw[BTN_INC] = 1'b1;
    push(t + 6, BTN_INC, EV_PRESS);
    step(8);
    chk("clean_level_hi", btn_level, 5'b01000);
    step(2);
    btn_raw[BTN_INC] = 1'b0;
    push(cyc + 6, BTN_INC, EV_REL);
    step(10);
    chk("clean_level_lo", btn_level, 5'b0);
    drained("clean");
    step(1);
    for (int i = 0; i < 6; i++) begin
      btn_raw[BTN_MODE] = ~i[0];
      step(2);
    end
    btn_raw[BTN_MODE] = 1'b1;
    push(cyc + 6, BTN_MODE, EV_PRESS);
    step(10);
    chk("bounce_level_hi", btn_level, 5'b00010);
    btn_raw[BTN_MODE] = 1'b0;
    push(cyc + 6, BTN_MODE, EV_REL);
    step(10);
    drained("bounce");
    step(1);
    t = cyc;
    btn_raw[BTN_INC] = 1'b1;
    btn_raw[BTN_START_STOP] = 1'b1;
    push(t + 6, BTN_START_STOP, EV_PRESS);
    push(t + 6, BTN_INC, EV_PRESS);
    push(t + 26, BTN_START_STOP, EV_HOLD);
    push(t + 26, BTN_INC, EV_HOLD);
    for (int r = 34; r <= 66; r += 8) push(t + r, BTN_INC, EV_REP);
    step(31);
    btn_raw[BTN_INC] = 1'b0;
    step(2);
    btn_raw[BTN_INC] = 1'b1;
    step(7);
    chk("glitch_level", btn_level, 5'b01001);
    step(26);
    btn_raw[BTN_INC] = 1'b0;
    btn_raw[BTN_START_STOP] = 1'b0;
    push(t + 72, BTN_START_STOP, EV_REL);
    push(t + 72, BTN_INC, EV_REL);
    step(12);
    chk("hold_level_lo", btn_level, 5'b0);
    drained("hold_repeat");
    step(1);
    reset = 1'b0;
    btn_raw[BTN_MODE] = 1'b1;
    step(3);
    chk_zero("held_reset");
    reset = 1'b1;
    step(20);
    chk("arm_level", btn_level, 5'b0);
    btn_raw[BTN_MODE] = 1'b0;
    step(4);
    btn_raw[BTN_MODE] = 1'b1;
    push(cyc + 6, BTN_MODE, EV_PRESS);
    step(10);
    chk("rearm_level", btn_level, 5'b00010);
    btn_raw[BTN_MODE] = 1'b0;
    push(cyc + 6, BTN_MODE, EV_REL);
    step(10);
    drained("arm");
    step(1);
    btn_raw[BTN_EDIT_SHIFT] = 1'b1;
    step(4);
    reset = 1'b0;
    #1;
    chk_zero("mid_deb_reset");
    step(3);
    btn_raw[BTN_EDIT_SHIFT] = 1'b0;
    reset = 1'b1;
    step(20);
    chk("after_reset_level", btn_level, 5'b0);
    drained("mid_deb");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
